// File: rtl/spi_frame_tx.sv
// SPI master with a word FIFO. Consecutive FIFO words are sent as one frame under a
// single slave-select assertion until a word tagged "last" is sent. Built for
// PmodCLS-class peripherals.
//
// Ports:
//   CLK, RST         system clock, synchronous active-high reset
//   s_data/s_last    word to send and end-of-frame tag, accepted when s_valid && s_ready
//   s_valid/s_ready  valid/ready write handshake into the FIFO
//   level            FIFO occupancy
//   busy             high unless idle with an empty FIFO
//   rx_data/rx_valid last word received on MISO plus a one-cycle update strobe
//   ss/mosi/miso/sclk SPI pins, ss active low
module spi_frame_tx #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned CLK_DIV = 50,
    parameter bit          CPOL    = 1'b0,
    parameter bit          CPHA    = 1'b0,
    parameter int unsigned GAP_CYC = 100
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [DATA_W-1:0]        s_data,
    input  logic                     s_last,
    input  logic                     s_valid,
    output logic                     s_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     busy,
    output logic [DATA_W-1:0]        rx_data,
    output logic                     rx_valid,
    output logic                     ss,
    output logic                     mosi,
    input  logic                     miso,
    output logic                     sclk
);

    localparam int unsigned AW     = $clog2(DEPTH);
    localparam int unsigned LVL_W  = AW + 1;
    localparam int unsigned DIV_W  = $clog2(CLK_DIV);
    localparam int unsigned EDGE_W = $clog2(2 * DATA_W);
    localparam int unsigned GAP_W  = $clog2(GAP_CYC + 1);

    localparam logic [DIV_W-1:0]  DIV_MAX  = DIV_W'(CLK_DIV - 1);
    localparam logic [EDGE_W-1:0] EDGE_MAX = EDGE_W'(2 * DATA_W - 1);
    localparam logic [GAP_W-1:0]  GAP_MAX  = GAP_W'(GAP_CYC - 1);
    localparam logic [LVL_W-1:0]  LVL_FULL = LVL_W'(DEPTH);

    typedef enum logic [2:0] {
        StIdle, StSetup, StShift, StHold, StWait, StGap
    } state_e;

    // FIFO storage and bookkeeping
    logic [DATA_W:0]    mem [DEPTH];
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]   level_q, level_d;
    logic               avail_q;
    logic               push, pop, fifo_ok;
    logic [DATA_W:0]    fifo_head;

    // Transfer engine
    state_e             state_q, state_d;
    logic [DIV_W-1:0]   div_q, div_d, div_inc;
    logic               div_wrap;
    logic [EDGE_W-1:0]  edge_q, edge_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [DATA_W-2:0]  tx_sr_q, tx_sr_d;   // bits still to send after the one on mosi
    logic [DATA_W-1:0]  rx_sr_q, rx_sr_d, rx_shift;
    logic               last_q, last_d;
    logic               sample_edge, drive_edge;

    // Registered outputs
    logic               ss_q, ss_d, sclk_q, sclk_d, mosi_q, mosi_d;
    logic [DATA_W-1:0]  rx_data_q, rx_data_d;
    logic               rx_valid_q, rx_valid_d, busy_q, busy_d;

    assign s_ready   = (level_q != LVL_FULL) && !RST;
    assign push      = s_valid && s_ready;
    assign fifo_head = mem[rd_ptr_q];
    // avail_q lags level by one cycle, so a fresh push is seen by the FSM one cycle late.
    // Pops are always followed by at least CLK_DIV cycles without a pop decision, so the
    // lag can never make the FSM pop an empty FIFO; the level check is a guard only.
    assign fifo_ok   = avail_q && (level_q != '0);

    assign level    = level_q;
    assign busy     = busy_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign ss       = ss_q;
    assign sclk     = sclk_q;
    assign mosi     = mosi_q;

    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr_q] <= {s_last, s_data};
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        unique case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    // Edge k (0-based) of a word is SPI edge k+1: odd SPI edges are leading edges.
    assign sample_edge = CPHA ? edge_q[0] : ~edge_q[0];
    assign drive_edge  = CPHA ? (~edge_q[0] && (edge_q != '0))
                              : (edge_q[0] && (edge_q != EDGE_MAX));
    assign rx_shift    = {rx_sr_q[DATA_W-2:0], miso};
    assign div_wrap    = (div_q == DIV_MAX);
    assign div_inc     = div_wrap ? '0 : div_q + DIV_W'(1);

    always_comb begin
        state_d    = state_q;
        div_d      = '0;
        edge_d     = edge_q;
        gap_d      = '0;
        tx_sr_d    = tx_sr_q;
        rx_sr_d    = rx_sr_q;
        last_d     = last_q;
        ss_d       = ss_q;
        sclk_d     = sclk_q;
        mosi_d     = mosi_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        pop        = 1'b0;

        unique case (state_q)
            StIdle: begin
                ss_d   = 1'b1;
                sclk_d = CPOL;
                if (fifo_ok) begin
                    pop     = 1'b1;
                    ss_d    = 1'b0;
                    state_d = StSetup;
                end
            end
            StSetup: begin
                div_d = div_inc;
                if (div_wrap) begin
                    edge_d  = '0;
                    state_d = StShift;
                end
            end
            StShift: begin
                div_d = div_inc;
                if (div_wrap) begin
                    sclk_d = ~sclk_q;
                    edge_d = edge_q + EDGE_W'(1);
                    if (sample_edge) begin
                        rx_sr_d = rx_shift;
                    end
                    if (drive_edge) begin
                        mosi_d  = tx_sr_q[DATA_W-2];
                        tx_sr_d = tx_sr_q << 1;
                    end
                    if (edge_q == EDGE_MAX) begin
                        rx_data_d  = sample_edge ? rx_shift : rx_sr_q;
                        rx_valid_d = 1'b1;
                        edge_d     = '0;
                        state_d    = StHold;
                    end
                end
            end
            StHold: begin
                div_d  = div_inc;
                sclk_d = CPOL;
                if (div_wrap) begin
                    if (last_q) begin
                        ss_d    = 1'b1;
                        state_d = StGap;
                    end else if (fifo_ok) begin
                        pop     = 1'b1;
                        state_d = StShift;
                    end else begin
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                sclk_d = CPOL;
                if (fifo_ok) begin
                    pop     = 1'b1;
                    state_d = StShift;
                end
            end
            StGap: begin
                ss_d  = 1'b1;
                gap_d = gap_q + GAP_W'(1);
                if (gap_q == GAP_MAX) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Every pop loads a fresh word with its MSB presented on mosi straight away.
        if (pop) begin
            last_d  = fifo_head[DATA_W];
            mosi_d  = fifo_head[DATA_W-1];
            tx_sr_d = fifo_head[DATA_W-2:0];
            rx_sr_d = '0;
        end

        busy_d = (state_d != StIdle) || (level_d != '0);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            avail_q    <= 1'b0;
            state_q    <= StIdle;
            div_q      <= '0;
            edge_q     <= '0;
            gap_q      <= '0;
            tx_sr_q    <= '0;
            rx_sr_q    <= '0;
            last_q     <= 1'b0;
            ss_q       <= 1'b1;
            sclk_q     <= CPOL;
            mosi_q     <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            avail_q    <= (level_q != '0);
            state_q    <= state_d;
            div_q      <= div_d;
            edge_q     <= edge_d;
            gap_q      <= gap_d;
            tx_sr_q    <= tx_sr_d;
            rx_sr_q    <= rx_sr_d;
            last_q     <= last_d;
            ss_q       <= ss_d;
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            busy_q     <= busy_d;
        end
    end

endmodule

// File: doc/spi_frame_tx.md
# spi_frame_tx

Parametrised, FIFO-buffered SPI master for PmodCLS-class peripherals. It replaces the fixed one-byte-at-a-time master/SPI pair with the following:
- a byte FIFO with a valid/ready write port;
- multi-byte frames under a single slave-select assertion;
- selectable SPI mode, clock divider and word width;
- a per-word MISO receive strobe.

It sits between a command/character sequencer and the Pmod pins (SS, MOSI, MISO, SCLK).

## Interface
Parameters:
- DATA_W, 8: bits per SPI word, MSB first.
- DEPTH, 16: FIFO depth in words; must be a power of 2 and ≥ 2.
- CLK_DIV, 50: CLK cycles per SCLK half-period, ≥ 2. At 100 MHz this gives a 1 MHz SCLK.
- CPOL, 0: SCLK idle level.
- CPHA, 0: 0 = sample on the leading edge; 1 = sample on the trailing edge.
- GAP_CYC, 100: minimum number of CLK cycles SS stays high between frames, ≥ 1.

Ports:
- CLK  in  1: system clock. One clock domain only.
- RST  in  1: synchronous, active-high reset.
- s_data  in  DATA_W: word to transmit.
- s_last  in  1: marks the final word of a frame.
- s_valid  in  1: write request.
- s_ready  out  1: FIFO can accept a word. Equals !full && !RST.
- level  out  $clog2(DEPTH)+1: current FIFO occupancy.
- busy  out  1: high in every state except IDLE, and also high whenever level ≠ 0.
- rx_data  out  DATA_W: last word received on MISO.
- rx_valid  out  1: one-cycle strobe when rx_data is updated.
- ss  out  1: active-low slave select.
- mosi  out  1: SPI data out.
- miso  in  1: SPI data in.
- sclk  out  1: SPI clock.

## Operation
- **FIFO.** Each entry holds {s_last, s_data}. A word is accepted on a CLK edge where s_valid && s_ready. The FSM pops from the head.
  - A push into an empty FIFO becomes visible to the FSM on the next cycle.
  - A simultaneous push and pop leaves level unchanged.
  - A push while full is impossible, because s_ready is low.
- **FSM states:** IDLE, SETUP, SHIFT, HOLD, WAIT, GAP.
- **IDLE:** ss=1 and sclk=CPOL. If the FIFO is non-empty, pop the head into the shift register, drive ss=0, and go to SETUP.
- **SETUP:** wait CLK_DIV cycles, with mosi = MSB already valid, then go to SHIFT.
- **SHIFT:** toggle sclk every CLK_DIV cycles, for exactly 2·DATA_W edges per word.
  - CPHA=0: sample miso on odd edges (1, 3, …); shift mosi on even edges except the last.
  - CPHA=1: shift mosi on odd edges; sample miso on even edges.
  - After the final edge, load the received word into rx_data, pulse rx_valid for one cycle, and go to HOLD.
- **HOLD:** wait CLK_DIV cycles with sclk=CPOL. Then:
  - if the word just sent had last=1, go to GAP;
  - otherwise, if the FIFO is non-empty, pop the next word and go to SHIFT (no SETUP);
  - otherwise go to WAIT.
- **WAIT (underrun mid-frame):** ss stays 0 and sclk stays CPOL. When the FIFO becomes non-empty, pop and go to SHIFT.
- **GAP:** ss=1 for GAP_CYC cycles, then go to IDLE.
- **Arithmetic and counters:**
  - The divider counter is $clog2(CLK_DIV) bits wide and wraps 0..CLK_DIV-1.
  - The edge counter counts 0..2·DATA_W-1.
  - The FIFO pointers are $clog2(DEPTH) bits and wrap naturally.
  - level = wr_count - rd_count, held in $clog2(DEPTH)+1 bits.

## Timing
- **Reset values:** ss=1, sclk=CPOL, mosi=0, rx_data=0, rx_valid=0, busy=0, level=0, FSM=IDLE.
- **Reset mid-operation:**
  - Reset takes effect on the next CLK edge.
  - The current word is aborted, the FIFO is flushed, and no rx_valid is produced.
- **Start latency:** a word accepted at edge N into an idle, empty block produces ss=0 registered at edge N+2.
- **Word period:**
  - first word: CLK_DIV (SETUP) + 2·DATA_W·CLK_DIV (SHIFT) + CLK_DIV (HOLD);
  - subsequent words of the same frame with no underrun: 2·DATA_W·CLK_DIV + CLK_DIV.
- **rx_valid:** asserts on the cycle after the final SCLK edge of each word.
- **Output glitches:** all outputs are registered; ss, sclk and mosi are glitch-free.
- **s_ready during reset:** low.

## Test plan
All scenarios use DATA_W=8, CLK_DIV=4, DEPTH=16, GAP_CYC=10, with miso looped back to mosi unless stated otherwise.

1. **Single word, mode 0.** Push 0xA5 with last=1.
   - mosi bits are 1,0,1,0,0,1,0,1.
   - ss is low for exactly 4+64+4 = 72 cycles.
   - rx_data=0xA5, with exactly one rx_valid pulse.
2. **Multi-word frame.** Push 0x1B, 0x5B, 0x6A, with last set only on the third word.
   - ss stays low continuously.
   - Three rx_valid pulses with data 0x1B, 0x5B, 0x6A.
   - ss is then high for ≥ 10 cycles.
3. **Full FIFO.** Hold s_valid high for 20 consecutive words 0x00..0x13.
   - s_ready drops when level reaches 16.
   - All 20 words are transmitted in order, with none lost or duplicated.
4. **Underrun mid-frame.** Push 0x11 (last=0), wait 200 cycles, then push 0x22 (last=1).
   - ss stays low throughout, and sclk is held at 0 during the wait.
   - Transmission resumes with 0x22.
5. **Reset mid-word.** After the 3rd SCLK edge, pulse RST for one cycle.
   - Next edge: ss=1, sclk=CPOL, level=0.
   - No rx_valid is produced.
   - A subsequent push of 0x55 transmits normally.
6. **Mode 3.** With CPOL=1 and CPHA=1, push 0x3C (last=1).
   - sclk idles high.
   - mosi changes only on falling edges.
   - rx_data=0x3C.
